parking_front_end: RTL

PARKING_FRONT_END -- requirements
Module: parking_front_end

---
 rtl/parking_front_end_pkg.sv | 15 +
 rtl/parking_front_end_if.sv | 28 ++
 rtl/sensor_debounce.sv | 43 ++++
 rtl/parking_front_end.sv | 128 ++++++++++++
 4 files changed

// File: rtl/parking_front_end_pkg.sv
// Shared parking definitions: digit width, digit type and key-entry FSM
// state encodings. Imported by the front end and by the gate controller.
package parking_front_end_pkg;

  localparam int DIGIT_W = 2;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } key_state_e;

endpackage

// File: rtl/parking_front_end_if.sv
// Keypad-side bus of the parking front end.
//   key_valid  : single-cycle digit strobe, key_code valid in the same cycle
//   key_code   : entered digit
//   key_clear  : single-cycle strobe discarding any entry
//   pass_1/2   : captured digits, zero unless pass_valid
//   pass_valid : a complete two-digit entry is held
// master drives the keypad strobes; slave is the front end.
interface parking_front_end_if;
  import parking_front_end_pkg::*;

  logic   key_valid;
  digit_t key_code;
  logic   key_clear;
  digit_t pass_1;
  digit_t pass_2;
  logic   pass_valid;

  modport master (
    output key_valid, key_code, key_clear,
    input  pass_1, pass_2, pass_valid
  );

  modport slave (
    input  key_valid, key_code, key_clear,
    output pass_1, pass_2, pass_valid
  );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter for one gate sensor.
//   clk     : system clock
//   reset   : asynchronous, active-low
//   din_raw : raw sensor, asynchronous to clk, may bounce
//   dout    : debounced level, changes after DEBOUNCE_CYC consecutive
//             synchronised samples that differ from it (2+DEBOUNCE_CYC latency)
module sensor_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic dout
);

  localparam logic [7:0] CNT_TC = 8'(DEBOUNCE_CYC - 1);

  logic       sync_1;
  logic       sync_2;
  logic [7:0] stable_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      stable_cnt <= 8'd0;
      dout       <= 1'b0;
    end else begin
      sync_1 <= din_raw;
      sync_2 <= sync_1;
      // any sample agreeing with the output restarts the stability window
      if (sync_2 == dout) begin
        stable_cnt <= 8'd0;
      end else if (stable_cnt == CNT_TC) begin
        dout       <= sync_2;
        stable_cnt <= 8'd0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/parking_front_end.sv
// Parking front end: debounces the entry/exit gate sensors and captures a
// two-digit password from the keypad for the gate controller.
//   clk             : system clock
//   reset           : asynchronous, active-low
//   sensor_ent_raw  : raw entry sensor
//   sensor_exit_raw : raw exit sensor
//   sensor_ent      : debounced entry sensor
//   sensor_exit     : debounced exit sensor
//   kp              : keypad strobes in, captured password out
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_EMPTY | no digits held, digit registers zero
// ST_ONE   | first digit held, waiting for second (timeout running)
// ST_TWO   | full entry presented; cleared by exit-sensor rise or clear
module parking_front_end
  import parking_front_end_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sensor_ent_raw,
  input  logic                 sensor_exit_raw,
  output logic                 sensor_ent,
  output logic                 sensor_exit,
  parking_front_end_if.slave   kp
);

  // loaded on entry to ST_ONE; terminal count 0 means TIMEOUT_CYC idle cycles
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC - 1);

  key_state_e  state, state_nxt;
  digit_t      digit_1, digit_1_nxt;
  digit_t      digit_2, digit_2_nxt;
  logic [15:0] tmo_cnt, tmo_cnt_nxt;
  logic        exit_q;
  logic        exit_rise;

  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_ent (
    .clk     (clk),
    .reset   (reset),
    .din_raw (sensor_ent_raw),
    .dout    (sensor_ent)
  );

  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_exit (
    .clk     (clk),
    .reset   (reset),
    .din_raw (sensor_exit_raw),
    .dout    (sensor_exit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_EMPTY;
      digit_1 <= '0;
      digit_2 <= '0;
      tmo_cnt <= 16'd0;
      exit_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      digit_1 <= digit_1_nxt;
      digit_2 <= digit_2_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      exit_q  <= sensor_exit;
    end
  end

  assign exit_rise = sensor_exit & ~exit_q;

  always_comb begin
    state_nxt   = state;
    digit_1_nxt = digit_1;
    digit_2_nxt = digit_2;
    tmo_cnt_nxt = tmo_cnt;

    if (kp.key_clear) begin
      state_nxt   = ST_EMPTY;
      digit_1_nxt = '0;
      digit_2_nxt = '0;
      tmo_cnt_nxt = 16'd0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (kp.key_valid) begin
            state_nxt   = ST_ONE;
            digit_1_nxt = kp.key_code;
            tmo_cnt_nxt = TMO_LOAD;
          end
        end
        ST_ONE: begin
          // a key in the expiry cycle still completes the entry
          if (kp.key_valid) begin
            state_nxt   = ST_TWO;
            digit_2_nxt = kp.key_code;
          end else if (tmo_cnt == 16'd0) begin
            state_nxt   = ST_EMPTY;
            digit_1_nxt = '0;
            digit_2_nxt = '0;
          end else begin
            tmo_cnt_nxt = tmo_cnt - 16'd1;
          end
        end
        ST_TWO: begin
          if (exit_rise) begin
            state_nxt   = ST_EMPTY;
            digit_1_nxt = '0;
            digit_2_nxt = '0;
          end
        end
        default: begin
          state_nxt   = ST_EMPTY;
          digit_1_nxt = '0;
          digit_2_nxt = '0;
          tmo_cnt_nxt = 16'd0;
        end
      endcase
    end
  end

  // digits are only presented with a complete entry
  assign kp.pass_valid = (state == ST_TWO);
  assign kp.pass_1     = (state == ST_TWO) ? digit_1 : '0;
  assign kp.pass_2     = (state == ST_TWO) ? digit_2 : '0;

endmodule
